// File: rtl/ctrl_pipe.sv
// ctrl_pipe: control-word pipeline behind decode with per-stage stall/flush.
// Define CTRL_PIPE_PERF_EN to add the bubble_cnt/flush_cnt performance counters.
module ctrl_pipe #(
    parameter int unsigned W      = 19,
    parameter int unsigned STAGES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [W-1:0]          in_ctrl,
    input  logic                  in_valid,
    input  logic [STAGES-1:0]     stall,
    input  logic [STAGES-1:0]     flush,
    output logic [STAGES*W-1:0]   out_ctrl,
    output logic [STAGES-1:0]     out_valid,
    output logic                  hold_up,
    output logic                  empty
`ifdef CTRL_PIPE_PERF_EN
    ,
    output logic [31:0]           bubble_cnt,
    output logic [31:0]           flush_cnt
`endif
);

    logic [STAGES-1:0] hold;
    logic [W-1:0]      ctrlQ [STAGES];
    logic [W-1:0]      ctrlD [STAGES];
    logic [STAGES-1:0] validQ;
    logic [STAGES-1:0] validD;

    // A stall anywhere downstream freezes every stage above it.
    always_comb begin
        hold = '0;
        hold[STAGES-1] = stall[STAGES-1];
        for (int unsigned i = 1; i < STAGES; i++) begin
            hold[STAGES-1-i] = stall[STAGES-1-i] | hold[STAGES-i];
        end
    end

    always_comb begin
        validD = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            ctrlD[k] = '0;
        end

        if (!flush[0]) begin
            if (hold[0]) begin
                ctrlD[0]  = ctrlQ[0];
                validD[0] = validQ[0];
            end else begin
                ctrlD[0]  = in_valid ? in_ctrl : '0;
                validD[0] = in_valid;
            end
        end

        // Flush wins over hold; a held upstream stage feeds a bubble downstream.
        for (int unsigned k = 1; k < STAGES; k++) begin
            if (!flush[k]) begin
                if (hold[k]) begin
                    ctrlD[k]  = ctrlQ[k];
                    validD[k] = validQ[k];
                end else if (!hold[k-1]) begin
                    ctrlD[k]  = ctrlQ[k-1];
                    validD[k] = validQ[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                ctrlQ[k] <= '0;
            end
            validQ <= '0;
        end else begin
            ctrlQ  <= ctrlD;
            validQ <= validD;
        end
    end

    always_comb begin
        out_ctrl = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            out_ctrl[k*W +: W] = ctrlQ[k];
        end
    end

    assign out_valid = validQ;
    assign hold_up   = hold[0];
    assign empty     = ~|validQ;

`ifdef CTRL_PIPE_PERF_EN
    logic lastBubble;
    logic flushHit;

    if (STAGES > 1) begin : gLastBubble
        always_comb begin
            lastBubble = !flush[STAGES-1] && !hold[STAGES-1] && hold[STAGES-2];
        end
    end else begin : gNoLastBubble
        always_comb begin
            lastBubble = 1'b0;
        end
    end

    always_comb begin
        flushHit = |(flush & validQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (lastBubble) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end
            if (flushHit) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: directed vectors plus a behavioural model
// compared every cycle; perf counters checked when CTRL_PIPE_PERF_EN is defined.
module tb_ctrl_pipe;
    localparam int unsigned W      = 19;
    localparam int unsigned STAGES = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic [W-1:0]        in_ctrl;
    logic                in_valid;
    logic [STAGES-1:0]   stall;
    logic [STAGES-1:0]   flush;
    logic [STAGES*W-1:0] out_ctrl;
    logic [STAGES-1:0]   out_valid;
    logic                hold_up;
    logic                empty;
`ifdef CTRL_PIPE_PERF_EN
    logic [31:0]         bubble_cnt;
    logic [31:0]         flush_cnt;
`endif

    int nChecks = 0;
    int nFail   = 0;

    always #5 clk = ~clk;

    ctrl_pipe #(.W(W), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_ctrl   (in_ctrl),
        .in_valid  (in_valid),
        .stall     (stall),
        .flush     (flush),
        .out_ctrl  (out_ctrl),
        .out_valid (out_valid),
        .hold_up   (hold_up),
`ifdef CTRL_PIPE_PERF_EN
        .bubble_cnt(bubble_cnt),
        .flush_cnt (flush_cnt),
`endif
        .empty     (empty)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: per-stage word/valid arrays, stage k is frozen when
    // any stall bit at index >= k is set.
    logic [W-1:0]      mCtrl [STAGES];
    logic [STAGES-1:0] mValid = '0;
    logic [31:0]       mBubble = '0;
    logic [31:0]       mFlush = '0;
    bit                live = 1'b0;

    initial begin
        for (int k = 0; k < STAGES; k++) mCtrl[k] = '0;
    end

    always @(posedge clk) begin
        logic [W-1:0]      nc [STAGES];
        logic [STAGES-1:0] nv;
        nv = '0;
        for (int k = 0; k < STAGES; k++) nc[k] = '0;
        if (rst) begin
            mBubble = '0;
            mFlush  = '0;
        end else begin
            if ((flush & mValid) != 0) mFlush = mFlush + 1;
            for (int k = 0; k < STAGES; k++) begin
                if (flush[k]) begin
                    nc[k] = '0;
                    nv[k] = 1'b0;
                end else if ((stall >> k) != 0) begin
                    nc[k] = mCtrl[k];
                    nv[k] = mValid[k];
                end else if (k == 0) begin
                    nc[k] = in_valid ? in_ctrl : '0;
                    nv[k] = in_valid;
                end else if (stall[k-1]) begin
                    nc[k] = '0;
                    nv[k] = 1'b0;
                    if (k == STAGES - 1) mBubble = mBubble + 1;
                end else begin
                    nc[k] = mCtrl[k-1];
                    nv[k] = mValid[k-1];
                end
            end
        end
        for (int k = 0; k < STAGES; k++) mCtrl[k] = nc[k];
        mValid = nv;
        live = 1'b1;
    end

    always @(negedge clk) begin
        logic [63:0] expCtrl;
        if (live) begin
            expCtrl = '0;
            for (int k = 0; k < STAGES; k++) expCtrl[k*W +: W] = mCtrl[k];
            chk("model_out_ctrl", 64'(out_ctrl), expCtrl);
            chk("model_out_valid", 64'(out_valid), 64'(mValid));
            chk("model_hold_up", 64'(hold_up), 64'(stall != 0));
            chk("model_empty", 64'(empty), 64'(mValid == 0));
`ifdef CTRL_PIPE_PERF_EN
            chk("model_bubble_cnt", 64'(bubble_cnt), 64'(mBubble));
            chk("model_flush_cnt", 64'(flush_cnt), 64'(mFlush));
`endif
        end
    end

    task automatic drive(input logic [W-1:0] c, input logic v,
                         input logic [STAGES-1:0] s, input logic [STAGES-1:0] f);
        in_ctrl  = c;
        in_valid = v;
        stall    = s;
        flush    = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [W-1:0] stageWord(input int k);
        return out_ctrl[k*W +: W];
    endfunction

    initial begin
        rst = 1'b1;
        drive('0, 1'b0, '0, '0);
        tick();
        tick();
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_ctrl", 64'(out_ctrl), 64'd0);
        chk("reset_empty", 64'(empty), 64'd1);
        rst = 1'b0;

        // Pass-through latency
        drive(19'h00001, 1'b1, '0, '0); tick();
        chk("pt_s0_cycle1", 64'(stageWord(0)), 64'h1);
        chk("pt_empty_cycle1", 64'(empty), 64'd0);
        drive(19'h00002, 1'b1, '0, '0); tick();
        chk("pt_s1_cycle2", 64'(stageWord(1)), 64'h1);
        chk("pt_s0_cycle2", 64'(stageWord(0)), 64'h2);
        drive(19'h00003, 1'b1, '0, '0); tick();
        chk("pt_s2_cycle3", 64'(stageWord(2)), 64'h1);
        chk("pt_valid_cycle3", 64'(out_valid), 64'b111);
        drive('0, 1'b0, '0, '0); tick(); tick(); tick();
        chk("drain_empty", 64'(empty), 64'd1);

        // Invalid input is zeroed
        drive(19'h7FFFF, 1'b0, '0, '0); tick();
        chk("inv_s0_word", 64'(stageWord(0)), 64'd0);
        chk("inv_s0_valid", 64'(out_valid[0]), 64'd0);

        // Hold propagation from stage 1
        drive(19'h0AAAA, 1'b1, '0, '0); tick();
        drive(19'h0BBBB, 1'b1, '0, '0); tick();
        drive(19'h0CCCC, 1'b1, 3'b010, '0); #1;
        chk("hold_up_on", 64'(hold_up), 64'd1);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("hold_s0", 64'(stageWord(0)), 64'h0BBBB);
            chk("hold_s1", 64'(stageWord(1)), 64'h0AAAA);
            chk("hold_s2_bubble", 64'(stageWord(2)), 64'd0);
            chk("hold_valid", 64'(out_valid), 64'b011);
        end
        drive(19'h0CCCC, 1'b1, '0, '0); #1;
        chk("hold_up_off", 64'(hold_up), 64'd0);
        tick();
        chk("resume_s2", 64'(stageWord(2)), 64'h0AAAA);
        chk("resume_s1", 64'(stageWord(1)), 64'h0BBBB);
        chk("resume_s0", 64'(stageWord(0)), 64'h0CCCC);
        drive('0, 1'b0, '0, '0); tick();
        chk("resume_s2_next", 64'(stageWord(2)), 64'h0BBBB);
        tick();
        chk("resume_s2_last", 64'(stageWord(2)), 64'h0CCCC);

        // Flush over hold at stage 0
        drive(19'h7FFFF, 1'b1, '0, '0); tick();
        chk("fh_loaded", 64'(stageWord(0)), 64'h7FFFF);
        drive(19'h12345, 1'b1, 3'b001, 3'b001); #1;
        chk("fh_hold_up", 64'(hold_up), 64'd1);
        tick();
        chk("fh_s0_word", 64'(stageWord(0)), 64'd0);
        chk("fh_s0_valid", 64'(out_valid[0]), 64'd0);
        drive('0, 1'b0, '0, '0);

        // Reset mid-flight
        drive(19'h00011, 1'b1, '0, '0); tick();
        drive(19'h00022, 1'b1, '0, '0); tick();
        drive(19'h00033, 1'b1, '0, '0); tick();
        chk("mid_all_valid", 64'(out_valid), 64'b111);
        rst = 1'b1;
        drive(19'h00044, 1'b1, 3'b101, 3'b010); tick();
        rst = 1'b0;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_ctrl", 64'(out_ctrl), 64'd0);
        chk("mid_rst_empty", 64'(empty), 64'd1);
`ifdef CTRL_PIPE_PERF_EN
        chk("mid_rst_bubble_cnt", 64'(bubble_cnt), 64'd0);
        chk("mid_rst_flush_cnt", 64'(flush_cnt), 64'd0);
`endif

        // Five hold-induced bubbles at the last stage, then two flushes of valid stages
        drive(19'h000A1, 1'b1, '0, '0); tick();
        drive(19'h000B2, 1'b1, '0, '0); tick();
        drive('0, 1'b0, 3'b010, '0);
        repeat (5) tick();
        drive('0, 1'b0, '0, 3'b001); tick();
        chk("perf_s1_after_flush0", 64'(stageWord(1)), 64'h000B2);
        drive('0, 1'b0, '0, 3'b010); tick();
        drive('0, 1'b0, '0, '0);
`ifdef CTRL_PIPE_PERF_EN
        chk("perf_bubble_cnt", 64'(bubble_cnt), 64'd5);
        chk("perf_flush_cnt", 64'(flush_cnt), 64'd2);
`endif

        // Mixed pseudo-random traffic, checked by the model every cycle
        for (int i = 0; i < 80; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            drive(W'($urandom), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 2) == 0) ? STAGES'($urandom) : '0,
                  ($urandom_range(0, 3) == 0) ? STAGES'($urandom) : '0);
            tick();
        end
        rst = 1'b0;
        drive('0, 1'b0, '0, '0);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 The block SHALL have parameter W, default 19, giving the control word width in bits (legal range 1..64).
REQ-002 The block SHALL have parameter STAGES, default 3, giving the number of pipeline stages after decode (legal range 1..8; stage 0 is E, stage 1 is M, stage 2 is W by default).
REQ-003 The block SHALL have a clk input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have a rst input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have an in_ctrl input, W bits: decode-stage control word.
REQ-006 The block SHALL have an in_valid input, 1 bit: in_ctrl holds a real instruction.
REQ-007 The block SHALL have a stall input, STAGES bits: bit k requests that stage k hold.
REQ-008 The block SHALL have a flush input, STAGES bits: bit k requests that stage k be cleared.
REQ-009 The block SHALL have an out_ctrl output, STAGES*W bits: stage k word on bits [k*W +: W].
REQ-010 The block SHALL have an out_valid output, STAGES bits: bit k set means stage k holds a real instruction.
REQ-011 The block SHALL have a hold_up output, 1 bit: decode must hold its instruction this cycle.
REQ-012 The block SHALL have an empty output, 1 bit: no stage is valid.

Function
REQ-013 The block SHALL compute the effective hold per stage as hold[STAGES-1] = stall[STAGES-1], and hold[k] = stall[k] | hold[k+1] for k < STAGES-1.
REQ-014 The block SHALL drive hold_up = hold[0] combinationally.
REQ-015 The block SHALL apply the following per-stage update priority at each clock edge: rst, then flush[k], then hold[k], then load.
REQ-016 A stage with flush[k]=1 SHALL load word 0 and valid 0, regardless of hold[k].
REQ-017 A stage with hold[k]=1 (and no flush) SHALL retain its word and valid unchanged.
REQ-018 Stage 0 SHALL load, when neither held nor flushed, in_valid ? in_ctrl : 0, with valid = in_valid.
REQ-019 Stage k>0 SHALL load, when neither held nor flushed, from stage k-1 if hold[k-1]=0; if hold[k-1]=1 it SHALL load a bubble (word 0, valid 0).
REQ-020 The block SHALL guarantee that a word with valid 0 is always all-zero, so any write-enable bit inside the word is inactive during a bubble.
REQ-021 Latency SHALL be exactly k+1 cycles from in_ctrl to stage k, given no hold or flush.
REQ-022 Outputs SHALL be registered, apart from hold_up and empty, which are combinational from registered state and stall.
REQ-023 A flush and a hold applied to the same stage in the same cycle SHALL result in a bubble, while upstream stages stay held.
REQ-024 The block SHALL drive empty = ~|out_valid.

Reset
REQ-025 When rst=1 at a clock edge, every out_ctrl bit and every out_valid bit SHALL become 0, regardless of stall and flush.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight words within that single cycle.
REQ-027 After reset, empty SHALL be 1.

Configuration
REQ-028 With macro CTRL_PIPE_PERF_EN defined, the block SHALL add a bubble_cnt output (32 bits) and a flush_cnt output (32 bits).
REQ-029 bubble_cnt SHALL increment each cycle in which the last stage loads a bubble caused by hold.
REQ-030 flush_cnt SHALL increment each cycle in which any flush bit clears a valid stage.
REQ-031 Both counters SHALL wrap modulo 2^32 and SHALL reset to 0.
REQ-032 Without CTRL_PIPE_PERF_EN, the ports and counters SHALL be absent and the remaining behaviour SHALL be identical.

Verification
REQ-033 Pass-through: W=19, STAGES=3, words 0x00001, 0x00002, 0x00003 with valid 1 and no stall -> 0x00001 appears at stage 0, 1 and 2 on cycles 1, 2 and 3; empty=0 from cycle 1.
REQ-034 Hold propagation: stall[1]=1 for 2 cycles while stage 1 holds 0x0AAAA -> stages 0 and 1 frozen and hold_up=1; stage 2 receives a bubble (0, valid 0) for 2 cycles; flow resumes without loss or duplication.
REQ-035 Flush over hold: stall[0]=1 and flush[0]=1 together while stage 0 holds 0x7FFFF -> stage 0 becomes 0 with valid 0 next cycle; hold_up=1 during that cycle.
REQ-036 Invalid input: in_valid=0, in_ctrl=0x7FFFF -> stage 0 word 0, out_valid[0]=0.
REQ-037 Reset mid-flight: all stages valid, rst=1 for one cycle -> all outputs 0 and empty=1 next cycle; perf counters (if enabled) read 0.
REQ-038 Perf: CTRL_PIPE_PERF_EN defined, 5 hold-induced bubbles at the last stage and 2 flushes of valid stages -> bubble_cnt=5, flush_cnt=2.
